// File: rtl/fetch_stage_if.sv
// Instruction-cache request/response bundle between the fetch stage and the I-cache.
interface fetch_stage_if;
  logic        re;     // read enable, fetch -> cache
  logic [31:0] addr;   // read address, fetch -> cache
  logic [31:0] dout;   // read data, cache -> fetch
  logic        stall;  // cache busy / miss in progress, cache -> fetch

  modport master (
    output re,
    output addr,
    input  dout,
    input  stall
  );

  modport slave (
    input  re,
    input  addr,
    output dout,
    output stall
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues sequential fetch addresses to the I-cache,
// absorbs downstream stalls (HOLD) and cache misses (MISS), and applies
// branch/jump redirects with a single killed slot. State advances on the
// falling clock edge.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_2000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  fetch_stage_if.master        icache,
  output logic [31:0]          pc_out,
  output logic [31:0]          inst_out,
  output logic                 fetch_stall
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    MISS = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] req_pc;
  logic [31:0] req_pc_next;
  logic [31:0] pc_q;
  logic [31:0] pc_q_next;
  logic        valid_q;
  logic        valid_next;
  logic [31:0] inst_hold;
  logic [31:0] inst_hold_next;

  // Fetch state and address registers, updated on the falling edge.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state     <= BOOT;
      req_pc    <= RESET_PC;
      pc_q      <= 32'h0000_0000;
      valid_q   <= 1'b0;
      inst_hold <= NOP_INST;
    end else begin
      state     <= state_next;
      req_pc    <= req_pc_next;
      pc_q      <= pc_q_next;
      valid_q   <= valid_next;
      inst_hold <= inst_hold_next;
    end
  end

  // Next-state logic; priority is cache miss, then redirect, then downstream stall.
  always_comb begin
    state_next     = state;
    req_pc_next    = req_pc;
    pc_q_next      = pc_q;
    valid_next     = valid_q;
    inst_hold_next = inst_hold;
    case (state)
      BOOT: begin
        state_next = RUN;
      end
      RUN, HOLD: begin
        if (icache.stall) begin
          // Miss: keep the slot in flight, but never lose a redirect.
          state_next = MISS;
          if (redirect_valid) begin
            req_pc_next = redirect_pc;
            valid_next  = 1'b0;
          end else begin
            valid_next  = valid_q;
          end
        end else if (!stall) begin
          // Advance: the address issued this edge becomes the next pc_out.
          state_next  = RUN;
          pc_q_next   = req_pc;
          valid_next  = ~redirect_valid;
          req_pc_next = redirect_valid ? redirect_pc : (req_pc + 32'd4);
        end else begin
          // Downstream stall: capture the cache word once, since the cache
          // moves on to req_pc after this edge.
          state_next = HOLD;
          if (state == RUN) begin
            inst_hold_next = icache.dout;
          end else begin
            inst_hold_next = inst_hold;
          end
          if (redirect_valid) begin
            req_pc_next = redirect_pc;
            valid_next  = 1'b0;
          end else begin
            req_pc_next = req_pc;
          end
        end
      end
      MISS: begin
        // Leave without advancing; the cache then presents the word for pc_q.
        if (icache.stall) begin
          state_next = MISS;
        end else begin
          state_next = RUN;
        end
        if (redirect_valid) begin
          req_pc_next = redirect_pc;
          valid_next  = 1'b0;
        end else begin
          req_pc_next = req_pc;
        end
      end
      default: begin
        state_next  = BOOT;
        req_pc_next = RESET_PC;
        valid_next  = 1'b0;
      end
    endcase
  end

  // Cache request: address always tracks req_pc; read only when a fetch can be taken.
  always_comb begin
    icache.addr = req_pc;
    case (state)
      RUN:     icache.re = 1'b1;
      HOLD:    icache.re = ~stall;
      default: icache.re = 1'b0;
    endcase
  end

  // Instruction to decode: bubbles, killed slots and redirect cycles show as NOP.
  always_comb begin
    pc_out      = pc_q;
    fetch_stall = (state == MISS);
    if (redirect_valid || !valid_q || (state == MISS)) begin
      inst_out = NOP_INST;
    end else if (state == HOLD) begin
      inst_out = inst_hold;
    end else if (state == RUN) begin
      inst_out = icache.dout;
    end else begin
      inst_out = NOP_INST;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a word=address I-cache model.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        fetch_stall;
  logic [31:0] lat_addr;
  int          n_checks;
  int          n_errors;

  fetch_stage_if ic ();

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .icache         (ic.master),
    .pc_out         (pc_out),
    .inst_out       (inst_out),
    .fetch_stall    (fetch_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cache model: accepts a read on the falling edge when not busy; data = address.
  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      lat_addr <= 32'h0000_0000;
    end else if (ic.re && !ic.stall) begin
      lat_addr <= ic.addr;
    end
  end
  assign ic.dout = ic.stall ? 32'hDEAD_BEEF : lat_addr;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [31:0] e_pc, input logic [31:0] e_inst,
                            input logic e_re, input logic [31:0] e_addr, input logic e_fs);
    #1;
    check_value({tag, "_pc"},   pc_out,   e_pc);
    check_value({tag, "_inst"}, inst_out, e_inst);
    check_value({tag, "_re"},   {31'd0, ic.re},  {31'd0, e_re});
    check_value({tag, "_addr"}, ic.addr,  e_addr);
    check_value({tag, "_fs"},   {31'd0, fetch_stall}, {31'd0, e_fs});
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    reset          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0000_0000;
    ic.stall       = 1'b0;

    // Reset and sequential fetch
    tick();
    expect_out("rst",   32'h0, NOP, 1'b0, 32'h2000, 1'b0);
    reset = 1'b1;
    expect_out("boot",  32'h0, NOP, 1'b0, 32'h2000, 1'b0);
    tick(); expect_out("run0",  32'h0,    NOP,      1'b1, 32'h2000, 1'b0);
    tick(); expect_out("f2000", 32'h2000, 32'h2000, 1'b1, 32'h2004, 1'b0);
    tick(); expect_out("f2004", 32'h2004, 32'h2004, 1'b1, 32'h2008, 1'b0);

    // Downstream stall for three edges while pc_out = 0x2008
    tick(); stall = 1'b1;
    expect_out("stall_run", 32'h2008, 32'h2008, 1'b1, 32'h200C, 1'b0);
    tick(); expect_out("hold1", 32'h2008, 32'h2008, 1'b0, 32'h200C, 1'b0);
    tick(); expect_out("hold2", 32'h2008, 32'h2008, 1'b0, 32'h200C, 1'b0);
    tick(); stall = 1'b0;
    expect_out("hold_rel", 32'h2008, 32'h2008, 1'b1, 32'h200C, 1'b0);
    tick(); expect_out("f200c", 32'h200C, 32'h200C, 1'b1, 32'h2010, 1'b0);

    // Redirect to 0x3000 while pc_out = 0x2010
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h3000;
    expect_out("redir",  32'h2010, NOP, 1'b1, 32'h2014, 1'b0);
    tick(); redirect_valid = 1'b0;
    expect_out("killed", 32'h2014, NOP, 1'b1, 32'h3000, 1'b0);
    tick(); expect_out("f3000", 32'h3000, 32'h3000, 1'b1, 32'h3004, 1'b0);
    tick(); expect_out("f3004", 32'h3004, 32'h3004, 1'b1, 32'h3008, 1'b0);

    // Redirect near the top of the address space: PC wraps to zero
    tick(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    expect_out("redir_wrap", 32'h3008, NOP, 1'b1, 32'h300C, 1'b0);
    tick(); redirect_valid = 1'b0;
    expect_out("kill_wrap", 32'h300C, NOP, 1'b1, 32'hFFFF_FFFC, 1'b0);
    tick(); expect_out("fwrap", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, 32'h0, 1'b0);
    tick(); expect_out("f0",    32'h0, 32'h0, 1'b1, 32'h4, 1'b0);

    // Reset mid-run, then cache miss after issuing 0x2014
    #1; reset = 1'b0;
    expect_out("rst_run", 32'h0, NOP, 1'b0, 32'h2000, 1'b0);
    tick(); reset = 1'b1;
    expect_out("boot2", 32'h0, NOP, 1'b0, 32'h2000, 1'b0);
    tick(); expect_out("run2", 32'h0, NOP, 1'b1, 32'h2000, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    ic.stall = 1'b1;
    #1;
    check_value("miss_pend_pc", pc_out, 32'h2014);
    check_value("miss_pend_fs", {31'd0, fetch_stall}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick(); expect_out("miss", 32'h2014, NOP, 1'b0, 32'h2018, 1'b1);
    end
    tick(); ic.stall = 1'b0;
    expect_out("miss_end", 32'h2014, NOP, 1'b0, 32'h2018, 1'b1);
    tick(); expect_out("miss_rec", 32'h2014, 32'h2014, 1'b1, 32'h2018, 1'b0);
    tick(); expect_out("f2018", 32'h2018, 32'h2018, 1'b1, 32'h201C, 1'b0);

    // Redirect to 0x4000 during MISS
    ic.stall = 1'b1;
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h4000;
    expect_out("miss_redir", 32'h2018, NOP, 1'b0, 32'h201C, 1'b1);
    tick(); redirect_valid = 1'b0;
    expect_out("miss_kill", 32'h2018, NOP, 1'b0, 32'h4000, 1'b1);
    ic.stall = 1'b0;
    tick(); expect_out("miss_out", 32'h2018, NOP, 1'b1, 32'h4000, 1'b0);
    tick(); expect_out("f4000", 32'h4000, 32'h4000, 1'b1, 32'h4004, 1'b0);

    // Redirect to 0x4000 during HOLD
    stall = 1'b1;
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h4000;
    expect_out("hold_redir", 32'h4000, NOP, 1'b0, 32'h4004, 1'b0);
    tick(); redirect_valid = 1'b0;
    expect_out("hold_kill", 32'h4000, NOP, 1'b0, 32'h4000, 1'b0);
    stall = 1'b0;
    tick(); expect_out("hold_out", 32'h4000, 32'h4000, 1'b1, 32'h4004, 1'b0);
    tick(); expect_out("f4004", 32'h4004, 32'h4004, 1'b1, 32'h4008, 1'b0);

    // Asynchronous reset in the middle of a miss
    ic.stall = 1'b1;
    tick(); expect_out("pre_rst_miss", 32'h4004, NOP, 1'b0, 32'h4008, 1'b1);
    #1; reset = 1'b0;
    expect_out("rst_miss", 32'h0, NOP, 1'b0, 32'h2000, 1'b0);
    tick(); ic.stall = 1'b0; reset = 1'b1;
    expect_out("boot3", 32'h0, NOP, 1'b0, 32'h2000, 1'b0);
    tick(); expect_out("run3",   32'h0,    NOP,      1'b1, 32'h2000, 1'b0);
    tick(); expect_out("f2000b", 32'h2000, 32'h2000, 1'b1, 32'h2004, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_2000: first fetch address after reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013: instruction emitted for bubbles and killed slots.
REQ-003 clk  input  1: single clock; all state updates on its falling edge.
REQ-004 reset  input  1: asynchronous, active-low reset.
REQ-005 stall  input  1: pipeline stall from hazard logic; 1 = downstream not accepting.
REQ-006 redirect_valid  input  1: branch/jump taken from Stage 2/X.
REQ-007 redirect_pc  input  32: target address, valid when redirect_valid=1.
REQ-008 icache_stall  input  1: 1 = instruction cache busy (miss); icache_dout not valid.
REQ-009 icache_dout  input  32: read data, valid the cycle after a falling edge with icache_re=1 and icache_stall=0.
REQ-010 icache_re  output  1: read enable to instruction cache.
REQ-011 icache_addr  output  32: read address to instruction cache.
REQ-012 pc_out  output  32: PC of the instruction on inst_out, to Stage 1/I.
REQ-013 inst_out  output  32: instruction to Stage 1/I.
REQ-014 fetch_stall  output  1: 1 while state is MISS.

Function
REQ-015 Internal registers SHALL be: state {BOOT, RUN, HOLD, MISS}, req_pc[31:0] (next address to issue), pc_q[31:0] (drives pc_out), valid_q, inst_hold[31:0].
REQ-016 icache_addr SHALL equal req_pc at all times.
REQ-017 icache_re SHALL be 1 in RUN, 1 in HOLD only while stall=0, and 0 in BOOT and MISS.
REQ-018 inst_out SHALL be NOP_INST when redirect_valid=1, when valid_q=0, or in MISS; otherwise inst_hold in HOLD and icache_dout in RUN.
REQ-019 BOOT: on the next falling edge, go to RUN; no other register changes.
REQ-020 RUN with icache_stall=0, stall=0: pc_q<=req_pc; valid_q<=~redirect_valid; req_pc<=redirect_valid ? redirect_pc : req_pc+4 (32-bit add, wraps modulo 2^32).
REQ-021 RUN with icache_stall=0, stall=1: go to HOLD; inst_hold<=icache_dout; pc_q and req_pc held, unless redirect_valid=1, in which case req_pc<=redirect_pc and valid_q<=0.
REQ-022 HOLD with stall=1: hold all registers, except redirect_valid=1 causes req_pc<=redirect_pc and valid_q<=0.
REQ-023 HOLD with stall=0: perform the REQ-020 update and go to RUN.
REQ-024 RUN or HOLD with icache_stall=1: go to MISS; pc_q, valid_q and inst_hold held.
REQ-025 MISS with icache_stall=1: remain in MISS; redirect_valid=1 causes req_pc<=redirect_pc and valid_q<=0.
REQ-026 MISS with icache_stall=0: return to RUN with no PC advance; the cache data for pc_q is then presented per REQ-018.
REQ-027 Priority per edge SHALL be: icache_stall > redirect_valid > stall. A redirect is never dropped, whatever the stall condition.
REQ-028 Redirect SHALL take effect with one killed slot: the instruction issued on the redirect edge carries valid_q=0.

Reset
REQ-029 When reset=0, the block SHALL immediately set state=BOOT, req_pc=RESET_PC, pc_q=0, valid_q=0, inst_hold=NOP_INST, giving pc_out=0, inst_out=NOP_INST, icache_re=0, fetch_stall=0.
REQ-030 Reset asserted mid-miss or mid-hold SHALL abandon the operation; after release, the first fetch issued is RESET_PC.

Verification
REQ-031 Reset release, stall=0, icache_stall=0, memory word=addr -> icache_addr 0x2000, 0x2004, 0x2008 on successive edges; pc_out/inst_out trail by one edge; the first valid inst_out is 0x2000.
REQ-032 stall=1 for 3 edges while pc_out=0x2008 -> pc_out and inst_out are held at 0x2008 with icache_re=0; after release, the next pc_out is 0x200C with no skipped or duplicated PC.
REQ-033 redirect_valid=1, redirect_pc=0x3000 while pc_out=0x2010 -> inst_out=NOP that cycle; the next slot is killed (NOP); then pc_out is 0x3000, then 0x3004.
REQ-034 icache_stall=1 for 4 cycles after issuing 0x2014 -> fetch_stall=1 and inst_out=NOP throughout; afterwards pc_out=0x2014 with correct data and the next issue is 0x2018.
REQ-035 Redirect to 0x4000 during MISS, and again during HOLD -> the killed instruction is never emitted; the first valid pc_out after recovery is 0x4000.
REQ-036 Assert reset=0 mid-MISS, asynchronous to clk -> outputs reach reset values immediately, and the first fetch after release is 0x2000.
